// File: rtl/pmem_responder_pkg.sv
// Shared types and constants for the cacheline memory responder.
package pmem_responder_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;

    // Byte-offset bits within a 16-byte cacheline; never used for line selection.
    localparam int unsigned LineOffsetW = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } pmem_state_e;

endpackage

// File: rtl/pmem_line_array.sv
// Backing store of 2**IDX_BITS cachelines: synchronous write, registered read, no reset.
module pmem_line_array import pmem_responder_pkg::*; #(
    parameter int unsigned IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [IDX_BITS-1:0] waddr_i,
    input  lc3b_cacheline       wdata_i,
    input  logic                re_i,
    input  logic [IDX_BITS-1:0] raddr_i,
    output lc3b_cacheline       rdata_o
);

    localparam int unsigned Lines = 2 ** IDX_BITS;

    lc3b_cacheline mem_q [Lines];
    lc3b_cacheline rdata_q;

    // Line write on the enabled edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; output holds between reads.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency, one-request-at-a-time cacheline memory responder.
module pmem_responder import pmem_responder_pkg::*; #(
    parameter int unsigned LATENCY  = 4,
    parameter int unsigned IDX_BITS = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pmem_read_i,
    input  logic          pmem_write_i,
    input  lc3b_word      pmem_address_i,
    input  lc3b_cacheline pmem_wdata_i,
    output logic          pmem_resp_o,
    output lc3b_cacheline pmem_rdata_o,
    output logic          perr_o
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("pmem_responder: LATENCY must be within 1..15");
    end

    localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

    pmem_state_e         state_q, state_d;
    logic                is_write_q, is_write_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    lc3b_cacheline       wdata_q, wdata_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                perr_q, perr_d;
    logic                rvalid_q, rvalid_d;
    logic                arr_re;
    logic                arr_we;
    lc3b_cacheline       arr_rdata;
    logic                req;
    logic                unused_addr;

    // Offset bits and aliasing upper bits are intentionally dropped.
    assign unused_addr = ^pmem_address_i;
    assign req         = pmem_read_i | pmem_write_i;

    // Next-state: accept, count down latency, pulse response.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        perr_d     = perr_q;
        arr_re     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    // A read+write collision resolves as a write.
                    is_write_d = pmem_write_i;
                    idx_d      = pmem_address_i[LineOffsetW +: IDX_BITS];
                    wdata_d    = pmem_wdata_i;
                    cnt_d      = CntLoad;
                    if (pmem_read_i && pmem_write_i) begin
                        perr_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        state_d = StResp;
                        arr_re  = ~pmem_write_i;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (!req) begin
                    perr_d = 1'b1;
                end
                // Leaving at count 1 makes the response land LATENCY cycles after acceptance.
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = StResp;
                    arr_re  = ~is_write_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Read data is masked to zero until the first read after reset.
    assign rvalid_d = rvalid_q | arr_re;

    // State and latch registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            cnt_q      <= 4'd0;
            perr_q     <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            perr_q     <= perr_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Write commits only at the edge that ends RESP, so a reset before then discards it.
    assign arr_we = (state_q == StResp) && is_write_q;

    pmem_line_array #(
        .IDX_BITS (IDX_BITS)
    ) u_line_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .re_i    (arr_re),
        .raddr_i (idx_d),
        .rdata_o (arr_rdata)
    );

    assign pmem_resp_o  = (state_q == StResp);
    assign pmem_rdata_o = rvalid_q ? arr_rdata : '0;
    assign perr_o       = perr_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder (LATENCY=4, IDX_BITS=6).
module tb_pmem_responder;

    logic         clk;
    logic         rst_n;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         perr;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] LA = 128'hAAAA_0000_1111_2222_3333_4444_5555_AAAA;
    localparam logic [127:0] LB = 128'hBBBB_9999_8888_7777_6666_5555_4444_BBBB;
    localparam logic [127:0] LC = 128'hC0DE_C0DE_0000_FFFF_1234_5678_9ABC_DEF0;
    localparam logic [127:0] LD = 128'hDDDD_DDDD_0101_0101_2020_2020_DDDD_DDDD;
    localparam logic [127:0] W2 = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;

    pmem_responder #(
        .LATENCY  (4),
        .IDX_BITS (6)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pmem_read_i    (pmem_read),
        .pmem_write_i   (pmem_write),
        .pmem_address_i (pmem_address),
        .pmem_wdata_i   (pmem_wdata),
        .pmem_resp_o    (pmem_resp),
        .pmem_rdata_o   (pmem_rdata),
        .perr_o         (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a request at a negedge, return latency in edges, read data and whether
    // resp was still high one cycle later. drop_after>0 deasserts after that many edges.
    task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [127:0] wd, input int drop_after,
                          output int lat, output logic [127:0] rdata, output logic dup);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        lat          = -1;
        rdata        = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (pmem_resp) begin
                lat   = n;
                rdata = pmem_rdata;
                break;
            end
            if (n == drop_after) begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dup = pmem_resp;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int           lat;
        logic [127:0] rd;
        logic         dup;

        rst_n        = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        // Reset held for 3 cycles, then idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_resp", 128'(pmem_resp), 128'(1'b0));
            chk("rst_rdata", pmem_rdata, '0);
            chk("rst_perr", 128'(perr), 128'(1'b0));
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_resp", 128'(pmem_resp), 128'(1'b0));
        chk("idle_rdata", pmem_rdata, '0);

        // Write then read the same line with offset bits set.
        do_req(1'b0, 1'b1, 16'h0040, D1, 0, lat, rd, dup);
        chk("wr_lat", 128'(lat), 128'(4));
        chk("wr_dup", 128'(dup), 128'(1'b0));
        do_req(1'b1, 1'b0, 16'h004E, '0, 0, lat, rd, dup);
        chk("rd_lat", 128'(lat), 128'(4));
        chk("rd_data", rd, D1);
        chk("rd_dup", 128'(dup), 128'(1'b0));
        chk("rd_hold", pmem_rdata, D1);

        // Aliasing: 0x0410 maps to the same line as 0x0010.
        do_req(1'b0, 1'b1, 16'h0010, LA, 0, lat, rd, dup);
        do_req(1'b0, 1'b1, 16'h0410, LB, 0, lat, rd, dup);
        do_req(1'b1, 1'b0, 16'h0010, '0, 0, lat, rd, dup);
        chk("alias_data", rd, LB);

        // Back-to-back: read then write issued the cycle after resp, then read back.
        do_req(1'b1, 1'b0, 16'h0100, '0, 0, lat, rd, dup);
        chk("b2b_rd_lat", 128'(lat), 128'(4));
        chk("b2b_rd_dup", 128'(dup), 128'(1'b0));
        do_req(1'b0, 1'b1, 16'h0200, W2, 0, lat, rd, dup);
        chk("b2b_wr_lat", 128'(lat), 128'(4));
        chk("b2b_wr_dup", 128'(dup), 128'(1'b0));
        do_req(1'b1, 1'b0, 16'h0200, '0, 0, lat, rd, dup);
        chk("b2b_rdback", rd, W2);
        chk("b2b_perr", 128'(perr), 128'(1'b0));

        // Reset mid-write: line 0x0080 starts at zero, aborted write must not land.
        do_req(1'b0, 1'b1, 16'h0080, '0, 0, lat, rd, dup);
        pmem_write   = 1'b1;
        pmem_address = 16'h0080;
        pmem_wdata   = {128{1'b1}};
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b0;
        pmem_write = 1'b0;
        chk("rstmid_resp0", 128'(pmem_resp), 128'(1'b0));
        repeat (2) @(negedge clk);
        chk("rstmid_resp1", 128'(pmem_resp), 128'(1'b0));
        chk("rstmid_rdata", pmem_rdata, '0);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (6) begin
                @(negedge clk);
                seen = seen | pmem_resp;
            end
            chk("rstmid_noresp", 128'(seen), 128'(1'b0));
        end
        do_req(1'b1, 1'b0, 16'h0080, '0, 0, lat, rd, dup);
        chk("rstmid_lat", 128'(lat), 128'(4));
        chk("rstmid_data", rd, '0);

        // Read and write together: treated as a write, perr set.
        do_req(1'b1, 1'b1, 16'h0300, LC, 0, lat, rd, dup);
        chk("both_lat", 128'(lat), 128'(4));
        chk("both_perr", 128'(perr), 128'(1'b1));
        do_req(1'b1, 1'b0, 16'h0300, '0, 0, lat, rd, dup);
        chk("both_wrote", rd, LC);
        pulse_reset();
        chk("perr_clr", 128'(perr), 128'(1'b0));

        // Request dropped mid-BUSY: resp still pulses, write still lands, perr sticks.
        do_req(1'b0, 1'b1, 16'h0500, LD, 2, lat, rd, dup);
        chk("drop_lat", 128'(lat), 128'(4));
        chk("drop_perr", 128'(perr), 128'(1'b1));
        do_req(1'b1, 1'b0, 16'h0500, '0, 0, lat, rd, dup);
        chk("drop_wrote", rd, LD);
        chk("drop_perr_sticky", 128'(perr), 128'(1'b1));
        pulse_reset();
        chk("drop_perr_clr", 128'(perr), 128'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Physical-memory-side responder for the cacheline bus driven by the data and instruction caches (pmem_read/pmem_write/pmem_address/pmem_wdata in, pmem_resp/pmem_rdata out).
- Provides a synthesizable, latency-configurable backing store of 128-bit lines.
- Used as the memory model in cache-level and CPU-level benches, and as on-chip memory in FPGA builds.
- Serves one request at a time: request accepted -> fixed latency -> single-cycle response.

Parameters:
- LATENCY, 4, cycles from request acceptance to the pmem_resp cycle; legal range 1..15.
- IDX_BITS, 6, line index width; store holds 2**IDX_BITS lines.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pmem_read  in  1  line read request; held by initiator until pmem_resp.
- pmem_write  in  1  line write request; held by initiator until pmem_resp.
- pmem_address  in  16  lc3b_word byte address; bits [3:0] ignored.
- pmem_wdata  in  128  lc3b_cacheline write data.
- pmem_resp  out  1  one-cycle completion pulse.
- pmem_rdata  out  128  lc3b_cacheline read data; valid in the pmem_resp cycle.
- perr  out  1  sticky protocol-error flag.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, asynchronous):
  - State forced to IDLE.
  - pmem_resp=0, pmem_rdata=0, perr=0, counter=0.
  - Line store contents are not reset.
- Line index is pmem_address[4+IDX_BITS-1:4]. Higher address bits alias, so the address wraps modulo 2**IDX_BITS lines.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If pmem_read or pmem_write is high at an edge, latch opcode, index and wdata.
  - Load counter = LATENCY-1.
  - Go to BUSY, or straight to RESP if LATENCY=1.
- BUSY:
  - Counter decrements each edge.
  - When counter reaches 0, go to RESP on the next edge.
  - Request-line changes are ignored; the latched values are used.
- Timing: a request first sampled at edge k produces pmem_resp high for exactly the cycle following edge k+LATENCY-1. Latency is LATENCY cycles, measured edge-to-resp-cycle.
- RESP:
  - pmem_resp=1 for one cycle.
  - Read: pmem_rdata = line[latched index], registered when entering RESP.
  - Write: line[latched index] is updated at the edge that ends RESP.
  - Then return to IDLE.
- Back-to-back requests: IDLE can accept a new request at the edge immediately after the RESP cycle. The initiator is required to update or drop its request at the edge where it samples pmem_resp.
- A read issued right after a write to the same line returns the new data.
- pmem_rdata holds its last value outside RESP. Only the RESP cycle is meaningful.
- Simultaneous pmem_read and pmem_write when accepted:
  - Treated as a write.
  - perr set.
- Request deasserted while BUSY (illegal):
  - perr set.
  - The operation still completes: write still commits, resp still pulses.
- perr clears only on reset.
- Reset asserted mid-operation (BUSY or RESP):
  - Operation aborted; no resp.
  - Pending write is discarded and the store is unmodified.
  - Returns to IDLE after rst_n deassertion.
- Counter width is 4 bits. LATENCY outside 1..15 is a parameter error, enforced by an elaboration assertion.

Decomposition:
- lc3b_types:
  - Reuse lc3b_word and lc3b_cacheline.
  - Add constant for the cacheline offset width (4).
  - Add an enum type for the responder FSM states.
- Sub-module pmem_line_array:
  - 2**IDX_BITS x 128-bit array.
  - Synchronous write with write-enable.
  - Synchronous read port; no reset.
  - Instantiated once.
- Top level holds the FSM, latch registers, counter and perr.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, no requests -> pmem_resp=0, pmem_rdata=0, perr=0 throughout.
- Write then read:
  - LATENCY=4: write 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 to address 0x0040, hold until resp -> resp exactly 4 cycles after acceptance.
  - Read 0x004E -> same line returned with resp at +4; address offset bits are ignored.
- Alias wrap: IDX_BITS=6, write line A to 0x0010 and line B to 0x0410 -> read 0x0010 returns B.
- Back-to-back:
  - Read to 0x0100 followed by a write to 0x0200 issued the cycle after resp -> second resp arrives exactly LATENCY cycles after the first resp cycle's edge.
  - No duplicate resp is issued.
- Protocol errors:
  - pmem_read and pmem_write both high -> treated as a write, perr=1.
  - Request dropped mid-BUSY -> resp still pulses and perr stays 1 until reset.
- Reset mid-write: assert rst_n low 2 cycles after accepting a write of 0xFFFF...FFFF to 0x0080 (previously 0) -> no resp; a subsequent read of 0x0080 returns 0.
